// File: rtl/cfg_pkg.sv
// Shared register offsets, bit positions and APB state encoding for the TPU configuration block.
package cfg_pkg;

  typedef enum logic {
    APB_IDLE = 1'b0,
    APB_RESP = 1'b1
  } apb_state_e;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_ENABLE = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN = 8'h10;
  localparam logic [7:0] OFF_ID     = 8'h14;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int STAT_DONE_BIT   = 0;
  localparam int STAT_STICKY_BIT = 1;
  localparam int STAT_BUSY_BIT   = 2;

endpackage

// File: rtl/cfg_run_counter.sv
// Run-cycle counter: synchronous clear has priority, counts while enabled, sticks at all-ones.
module cfg_run_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cfg.sv
// APB configuration/status slave for the TPU control FSM: stage enables, start/done handshake,
// done interrupt and run-cycle counter. One wait state per transfer.
module cfg
  import cfg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5450_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  start_tpu,
  output logic                  enable_matmul,
  output logic                  enable_norm,
  output logic                  enable_pool,
  output logic                  enable_activation,
  input  logic                  done_tpu,
  output logic                  irq
);

  apb_state_e           state_q, state_d;
  logic [31:0]          prdata_q, prdata_d;
  logic                 pslverr_q, pslverr_d;
  logic                 start_q, start_d;
  logic                 auto_clear_q, auto_clear_d;
  logic [3:0]           enable_q, enable_d;
  logic                 sticky_q, sticky_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;
  logic                 done_q;

  logic [ADDR_WIDTH-1:0] addr_w;
  logic                  access, wr, busy, done_rise;
  logic                  addr_err, ro_err, en_busy_err, reject, wr_ok, warn;
  logic [31:0]           rd_data;
  logic [CNT_WIDTH-1:0]  cycles;
  logic                  cnt_clr;
  logic                  unused_ok;

  assign addr_w    = {PADDR[ADDR_WIDTH-1:2], 2'b00};
  assign access    = (state_q == APB_IDLE) && PSEL && PENABLE;
  assign wr        = access && PWRITE;
  assign busy      = start_q & ~done_tpu;
  assign done_rise = done_tpu & ~done_q;
  assign unused_ok = ^{PADDR[1:0], PWDATA[31:4]};

  // Address decode: read mux plus the three reasons a transfer is rejected
  always_comb begin
    rd_data     = '0;
    addr_err    = 1'b0;
    ro_err      = 1'b0;
    en_busy_err = 1'b0;
    case (addr_w)
      ADDR_WIDTH'(OFF_CTRL):   rd_data = {30'b0, auto_clear_q, start_q};
      ADDR_WIDTH'(OFF_ENABLE): begin
        rd_data     = {28'b0, enable_q};
        en_busy_err = PWRITE && busy;
      end
      ADDR_WIDTH'(OFF_STATUS): rd_data = {29'b0, busy, sticky_q, done_tpu};
      ADDR_WIDTH'(OFF_CYCLES): begin
        rd_data = 32'(cycles);
        ro_err  = PWRITE;
      end
      ADDR_WIDTH'(OFF_IRQ_EN): rd_data = {31'b0, irq_en_q};
      ADDR_WIDTH'(OFF_ID): begin
        rd_data = ID_VALUE;
        ro_err  = PWRITE;
      end
      default: addr_err = 1'b1;
    endcase
    reject = addr_err | ro_err | en_busy_err;
    wr_ok  = wr & ~reject;
    // Starting without matmul enabled is allowed but flagged back to software
    warn   = wr_ok && (addr_w == ADDR_WIDTH'(OFF_CTRL)) && PWDATA[CTRL_START_BIT] && !enable_q[0];
  end

  always_comb begin
    state_d   = state_q;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (access) begin
          state_d   = APB_RESP;
          prdata_d  = (PWRITE || reject) ? 32'h0 : rd_data;
          pslverr_d = reject | warn;
        end
      end
      APB_RESP: state_d = APB_IDLE;
      default:  state_d = APB_IDLE;
    endcase
  end

  // Register updates: APB write overrides auto-clear, done_rise overrides W1C
  always_comb begin
    start_d      = start_q;
    auto_clear_d = auto_clear_q;
    enable_d     = enable_q;
    sticky_d     = sticky_q;
    irq_en_d     = irq_en_q;
    if (done_rise && auto_clear_q) start_d = 1'b0;
    if (wr_ok) begin
      case (addr_w)
        ADDR_WIDTH'(OFF_CTRL): begin
          start_d      = PWDATA[CTRL_START_BIT];
          auto_clear_d = PWDATA[CTRL_AUTO_BIT];
        end
        ADDR_WIDTH'(OFF_ENABLE): enable_d = PWDATA[3:0];
        ADDR_WIDTH'(OFF_STATUS): if (PWDATA[STAT_STICKY_BIT]) sticky_d = 1'b0;
        ADDR_WIDTH'(OFF_IRQ_EN): irq_en_d = PWDATA[0];
        default: ;
      endcase
    end
    if (done_rise) sticky_d = 1'b1;
    irq_d = sticky_q & irq_en_q;
  end

  assign cnt_clr = start_d & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= APB_IDLE;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      start_q      <= 1'b0;
      auto_clear_q <= 1'b0;
      enable_q     <= '0;
      sticky_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      start_q      <= start_d;
      auto_clear_q <= auto_clear_d;
      enable_q     <= enable_d;
      sticky_q     <= sticky_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      done_q       <= done_tpu;
    end
  end

  cfg_run_counter #(.CNT_WIDTH(CNT_WIDTH)) u_run_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (busy),
    .count (cycles)
  );

  assign PREADY            = (state_q == APB_RESP);
  assign PRDATA            = prdata_q;
  assign PSLVERR           = pslverr_q;
  assign start_tpu         = start_q;
  assign enable_matmul     = enable_q[0];
  assign enable_norm       = enable_q[1];
  assign enable_pool       = enable_q[2];
  assign enable_activation = enable_q[3];
  assign irq               = irq_q;

endmodule

// File: tb/tb_cfg.sv
// Directed bench for cfg: APB transfers queue their expected response, popped when PREADY arrives.
module tb_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        start_tpu, enable_matmul, enable_norm, enable_pool, enable_activation;
  logic        done_tpu;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_waits;
  int          resp_cyc;
  int          start_cyc;
  logic [32:0] exp_q[$];
  string       tag_q[$];

  cfg dut (
    .clk               (clk),
    .reset             (reset),
    .PADDR             (PADDR),
    .PWRITE            (PWRITE),
    .PSEL              (PSEL),
    .PENABLE           (PENABLE),
    .PWDATA            (PWDATA),
    .PRDATA            (PRDATA),
    .PREADY            (PREADY),
    .PSLVERR           (PSLVERR),
    .start_tpu         (start_tpu),
    .enable_matmul     (enable_matmul),
    .enable_norm       (enable_norm),
    .enable_pool       (enable_pool),
    .enable_activation (enable_activation),
    .done_tpu          (done_tpu),
    .irq               (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    logic [32:0] exp;
    string       t;
    int          waits;
    exp_q.push_back({exp_err, exp_rd});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge clk);
    while (PREADY !== 1'b1 && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    last_waits = waits;
    resp_cyc   = cyc;
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    if (waits >= 8) begin
      checks++;
      errors++;
      $display("FAIL %s: PREADY never arrived within 8 cycles, required 1", t);
    end else begin
      chk({31'b0, PSLVERR, PRDATA}, {31'b0, exp}, t);
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({24'b0, start_tpu, enable_matmul, enable_norm, enable_pool, enable_activation,
         irq, PREADY, PSLVERR, PRDATA}, 64'h0, tag);
  endtask

  initial begin
    reset = 1'b1; PADDR = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    PWDATA = '0; done_tpu = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1. reset state and ID
    @(negedge clk);
    chk_all_zero("reset_outputs");
    xfer(1'b0, 8'h14, 32'h0, 32'h5450_0001, 1'b0, "read_id");
    chk(64'(last_waits), 64'd1, "pready_latency");
    @(negedge clk);
    chk({63'b0, PREADY}, 64'h0, "pready_one_cycle");
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, "read_cycles_reset");
    xfer(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, "read_ctrl_reset");

    // 2. run with auto_clear off
    xfer(1'b1, 8'h04, 32'hF, 32'h0, 1'b0, "write_enable");
    chk({60'b0, enable_activation, enable_pool, enable_norm, enable_matmul}, 64'hF, "enable_outputs");
    xfer(1'b1, 8'h00, 32'h1, 32'h0, 1'b0, "write_ctrl_start");
    start_cyc = resp_cyc;
    chk({63'b0, start_tpu}, 64'h1, "start_set");
    xfer(1'b0, 8'h08, 32'h0, 32'h4, 1'b0, "status_busy");
    repeat (start_cyc + 10 - cyc) @(posedge clk);
    #1 done_tpu = 1'b1;
    xfer(1'b0, 8'h0C, 32'h0, 32'd10, 1'b0, "cycles_10");
    xfer(1'b0, 8'h08, 32'h0, 32'h3, 1'b0, "status_done_sticky");
    chk({62'b0, start_tpu, irq}, 64'h2, "start_held_no_irq");

    // 3. auto_clear, irq, W1C
    done_tpu = 1'b0;
    xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, "w1c_sticky");
    xfer(1'b0, 8'h08, 32'h0, 32'h4, 1'b0, "status_after_w1c");
    xfer(1'b1, 8'h00, 32'h0, 32'h0, 1'b0, "ctrl_zero");
    xfer(1'b1, 8'h00, 32'h3, 32'h0, 1'b0, "ctrl_auto");
    xfer(1'b0, 8'h00, 32'h0, 32'h3, 1'b0, "read_ctrl_auto");
    @(posedge clk); #1 done_tpu = 1'b1;
    @(negedge clk);
    chk({63'b0, start_tpu}, 64'h1, "start_before_rise");
    @(negedge clk);
    chk({63'b0, start_tpu}, 64'h0, "auto_cleared");
    xfer(1'b1, 8'h10, 32'h1, 32'h0, 1'b0, "irq_en");
    chk({63'b0, irq}, 64'h1, "irq_set");
    xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, "w1c_irq");
    chk({63'b0, irq}, 64'h0, "irq_cleared");
    xfer(1'b0, 8'h08, 32'h0, 32'h1, 1'b0, "status_live_done");

    // 4. error responses and enable constraint
    done_tpu = 1'b0;
    xfer(1'b1, 8'h00, 32'h1, 32'h0, 1'b0, "restart");
    xfer(1'b1, 8'h04, 32'h0, 32'h0, 1'b1, "enable_while_busy");
    xfer(1'b0, 8'h04, 32'h0, 32'hF, 1'b0, "enable_unchanged");
    xfer(1'b1, 8'h3C, 32'h5, 32'h0, 1'b1, "write_unmapped");
    xfer(1'b0, 8'h3C, 32'h0, 32'h0, 1'b1, "read_unmapped");
    xfer(1'b1, 8'h0C, 32'h7, 32'h0, 1'b1, "write_cycles_ro");
    xfer(1'b1, 8'h14, 32'h7, 32'h0, 1'b1, "write_id_ro");
    done_tpu = 1'b1;
    xfer(1'b1, 8'h04, 32'h0, 32'h0, 1'b0, "enable_zero_idle");
    xfer(1'b1, 8'h00, 32'h1, 32'h0, 1'b1, "start_no_matmul");
    chk({63'b0, start_tpu}, 64'h1, "start_no_matmul_taken");
    xfer(1'b0, 8'h00, 32'h0, 32'h1, 1'b0, "read_ctrl_warn");
    xfer(1'b1, 8'h04, 32'hF, 32'h0, 1'b0, "enable_restore");

    // 5. simultaneous events
    done_tpu = 1'b0;
    fork
      xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, "w1c_vs_rise");
      begin
        @(posedge clk); @(posedge clk); #1 done_tpu = 1'b1;
      end
    join
    xfer(1'b0, 8'h08, 32'h0, 32'h3, 1'b0, "sticky_set_wins");
    done_tpu = 1'b0;
    xfer(1'b1, 8'h00, 32'h3, 32'h0, 1'b0, "ctrl_auto_again");
    fork
      xfer(1'b1, 8'h00, 32'h1, 32'h0, 1'b0, "ctrl_vs_autoclear");
      begin
        @(posedge clk); @(posedge clk); #1 done_tpu = 1'b1;
      end
    join
    chk({63'b0, start_tpu}, 64'h1, "apb_wins_autoclear");
    xfer(1'b0, 8'h00, 32'h0, 32'h1, 1'b0, "read_ctrl_apb_wins");

    // 6. reset during the response phase of a write
    done_tpu = 1'b0;
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(negedge clk);
    chk({63'b0, PREADY}, 64'h0, "mid_pre_resp");
    @(negedge clk);
    chk({63'b0, PREADY}, 64'h1, "mid_resp");
    reset = 1'b1;
    @(negedge clk);
    chk({63'b0, PREADY}, 64'h0, "mid_reset_1");
    @(negedge clk);
    chk({63'b0, PREADY}, 64'h0, "mid_reset_2");
    reset = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_outputs");
    xfer(1'b0, 8'h10, 32'h0, 32'h0, 1'b0, "irq_en_after_reset");
    xfer(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, "ctrl_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
